control_seq: RTL and testbench
==============================

CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 SHALL have parameter DW, default 8: accumulator/ALU result width used for zero-flag evaluation.
REQ-002 SHALL have parameter FLAGS_LIVE, default 0: 0 = jump conditions use registered flags; 1 = jump conditions use live alu_zero/alu_carry.
REQ-003 SHALL have port clk  in  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port ir  in  8  held instruction {bit7,bit6,src[1:0],indexed,dest[2:0]}.
REQ-006 SHALL have port mem_ready  in  1  memory handshake; current memory access completes this cycle.
REQ-007 SHALL have port alu_result  in  DW  ALU output, sampled for zero flag.
REQ-008 SHALL have port alu_carry  in  1  ALU carry-out.
REQ-009 SHALL have ports load_ir, pc_inc, load_pc, load_a, load_b, load_x, load_q, store_mem  out  1 each  active-high one-cycle strobes.
REQ-010 SHALL have port assert_bar  out  4  active-low one-hot bus source select [M,E,A,X] = bits [0..3].
REQ-011 SHALL have ports immediate, do_subtract, do_jump, halted, flag_z, flag_c  out  1 each.

Function
REQ-012 SHALL implement states FETCH, EXEC, HALT.
REQ-013 FETCH: load_ir=1 and assert_bar=4'b1110 every cycle; pc_inc=1 only when mem_ready=1; mem_ready=1 -> EXEC, else stay.
REQ-014 EXEC: decode ir; exactly one destination strobe asserted, for one cycle, then -> FETCH.
REQ-015 Dest decode: 1=load_pc (taken jumps only), 2=load_a, 3=load_b, 4=load_x, 5=store_mem, 6=load_q, 0=NOP (no strobe), 7=HALT.
REQ-016 EXEC with src==0 or dest==5 SHALL stall while mem_ready=0, with all strobes low; strobe asserted and FETCH entered in the mem_ready=1 cycle.
REQ-017 assert_bar in EXEC SHALL be ~(1<<src); immediate = ~indexed; do_subtract = bit6; values valid throughout EXEC, including stall cycles.
REQ-018 Jump condition = (bit6 & Z) | (bit7 & C) | (bit6 & bit7), where Z/C are flag_z/flag_c (FLAGS_LIVE=0) or alu_result==0/alu_carry (FLAGS_LIVE=1).
REQ-019 do_jump = load_pc; dest==1 with false condition SHALL assert no strobe and return to FETCH.
REQ-020 On the edge ending a load_a cycle, flag_z <= (alu_result=={DW{1'b0}}) and flag_c <= alu_carry; flags hold in all other cycles.
REQ-021 dest==7 in EXEC -> HALT; HALT asserts halted=1, no strobes, assert_bar=4'b1111; leaves only via reset.
REQ-022 Strobes SHALL be combinational from state, ir and mem_ready; state and flags registered.

Reset
REQ-023 reset_n=0 SHALL immediately force state FETCH, flag_z=0, flag_c=0, halted=0, regardless of clock.
REQ-024 While reset_n=0, all strobes SHALL be 0 and assert_bar=4'b1111; a reset during an EXEC stall SHALL abandon the access with no strobe.
REQ-025 First cycle after reset_n rises SHALL be a normal FETCH cycle.

Structure
REQ-026 Shared package nic8_ctrl_pkg SHALL hold the state enum, dest codes (DEST_NOP..DEST_HALT) and source codes (SRC_M, SRC_E, SRC_A, SRC_X).
REQ-027 Combinational ir field decode SHALL be a sub-module ctrl_decode; control_seq holds the FSM, flags and handshake.

Verification
REQ-028 Reset: reset_n=0 mid-EXEC -> strobes 0 without a clock edge, flag_z=0, flag_c=0, halted=0; release -> load_ir=1 in FETCH.
REQ-029 ir=0x02, mem_ready=1, alu_result=0 -> FETCH with pc_inc=1, then EXEC with load_a=1 and assert_bar=4'b1110; flag_z=1 after edge.
REQ-030 ir=0x51: flag_z=1 -> load_pc=1, do_jump=1; flag_z=0 -> no strobe, next state FETCH; ir=0xC1 -> jump with flags 0.
REQ-031 ir=0x25 with mem_ready low for 3 EXEC cycles -> store_mem=0, assert_bar=4'b1011 held; 4th cycle mem_ready=1 -> store_mem=1 for exactly one cycle.
REQ-032 ir=0x07 -> halted=1, no strobes for 10+ cycles despite mem_ready toggling; reset_n pulse -> FETCH, halted=0.
REQ-033 FLAGS_LIVE=1, ir=0x51, alu_result=0, flag_z=0 -> jump taken.

Source files
------------

// File: rtl/nic8_ctrl_pkg.sv
// Shared types and field codes for the nic8 control sequencer.
// Holds the FSM state enum, destination/source codes and the bus-select helper.
package nic8_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } ctrlStateT;

  localparam logic [2:0] DEST_NOP  = 3'd0;
  localparam logic [2:0] DEST_JUMP = 3'd1;
  localparam logic [2:0] DEST_A    = 3'd2;
  localparam logic [2:0] DEST_B    = 3'd3;
  localparam logic [2:0] DEST_X    = 3'd4;
  localparam logic [2:0] DEST_MEM  = 3'd5;
  localparam logic [2:0] DEST_Q    = 3'd6;
  localparam logic [2:0] DEST_HALT = 3'd7;

  localparam logic [1:0] SRC_M = 2'd0;
  localparam logic [1:0] SRC_E = 2'd1;
  localparam logic [1:0] SRC_A = 2'd2;
  localparam logic [1:0] SRC_X = 2'd3;

  // Active-low one-hot bus driver select for a source code.
  function automatic logic [3:0] busSelect(input logic [1:0] src);
    return ~(4'b0001 << src);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational field decode of the held instruction register.
// ir = {bit7, bit6, src[1:0], indexed, dest[2:0]}.
module ctrl_decode
  import nic8_ctrl_pkg::*;
(
  input  logic [7:0] ir,
  output logic [2:0] dest,
  output logic [3:0] busSel,
  output logic       needsMem,
  output logic       immSel,
  output logic       subSel,
  output logic       condZSel,
  output logic       condCSel
);

  logic [1:0] src;

  assign src      = ir[5:4];
  assign dest     = ir[2:0];
  assign busSel   = busSelect(src);
  // Memory is touched when reading from M or writing to memory.
  assign needsMem = (src == SRC_M) || (dest == DEST_MEM);
  assign immSel   = ~ir[3];
  assign subSel   = ir[6];
  assign condZSel = ir[6];
  assign condCSel = ir[7];

endmodule

// File: rtl/control_seq.sv
// Fetch/execute control sequencer: FSM, condition flags and memory handshake.
// Strobes are combinational from state, ir and mem_ready; state and flags are registered.
//
// state | meaning
// FETCH | drive memory onto bus, load ir; advance when mem_ready
// EXEC  | decode ir, fire one destination strobe (stall on memory)
// HALT  | stopped, no strobes; exit only through reset
module control_seq
  import nic8_ctrl_pkg::*;
#(
  parameter int DW         = 8,
  parameter int FLAGS_LIVE = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    ir,
  input  logic          mem_ready,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_carry,
  output logic          load_ir,
  output logic          pc_inc,
  output logic          load_pc,
  output logic          load_a,
  output logic          load_b,
  output logic          load_x,
  output logic          load_q,
  output logic          store_mem,
  output logic [3:0]    assert_bar,
  output logic          immediate,
  output logic          do_subtract,
  output logic          do_jump,
  output logic          halted,
  output logic          flag_z,
  output logic          flag_c
);

  ctrlStateT  state, nextState;
  logic [2:0] dest;
  logic [3:0] busSel;
  logic       needsMem, immSel, subSel, condZSel, condCSel;
  logic       aluZero, condZ, condC, takeJump;

  ctrl_decode uDecode (
    .ir       (ir),
    .dest     (dest),
    .busSel   (busSel),
    .needsMem (needsMem),
    .immSel   (immSel),
    .subSel   (subSel),
    .condZSel (condZSel),
    .condCSel (condCSel)
  );

  assign aluZero  = (alu_result == {DW{1'b0}});
  assign condZ    = (FLAGS_LIVE != 0) ? aluZero   : flag_z;
  assign condC    = (FLAGS_LIVE != 0) ? alu_carry : flag_c;
  assign takeJump = (condZSel & condZ) | (condCSel & condC) | (condZSel & condCSel);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (load_a) begin
      flag_z <= aluZero;
      flag_c <= alu_carry;
    end
  end

  always_comb begin
    nextState   = state;
    load_ir     = 1'b0;
    pc_inc      = 1'b0;
    load_pc     = 1'b0;
    load_a      = 1'b0;
    load_b      = 1'b0;
    load_x      = 1'b0;
    load_q      = 1'b0;
    store_mem   = 1'b0;
    assert_bar  = 4'b1111;
    immediate   = 1'b0;
    do_subtract = 1'b0;
    halted      = 1'b0;

    case (state)
      FETCH: begin
        load_ir    = 1'b1;
        assert_bar = busSelect(SRC_M);
        pc_inc     = mem_ready;
        if (mem_ready) nextState = EXEC;
      end
      EXEC: begin
        assert_bar  = busSel;
        immediate   = immSel;
        do_subtract = subSel;
        if (!needsMem || mem_ready) begin
          nextState = FETCH;
          case (dest)
            DEST_JUMP: load_pc   = takeJump;
            DEST_A:    load_a    = 1'b1;
            DEST_B:    load_b    = 1'b1;
            DEST_X:    load_x    = 1'b1;
            DEST_MEM:  store_mem = 1'b1;
            DEST_Q:    load_q    = 1'b1;
            DEST_HALT: nextState = HALT;
            default:   ;
          endcase
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: nextState = FETCH;
    endcase

    // Outputs are quiet while reset is held, without waiting for a clock.
    if (!reset_n) begin
      nextState   = FETCH;
      load_ir     = 1'b0;
      pc_inc      = 1'b0;
      load_pc     = 1'b0;
      load_a      = 1'b0;
      load_b      = 1'b0;
      load_x      = 1'b0;
      load_q      = 1'b0;
      store_mem   = 1'b0;
      assert_bar  = 4'b1111;
      immediate   = 1'b0;
      do_subtract = 1'b0;
      halted      = 1'b0;
    end
  end

  assign do_jump = load_pc;

endmodule

// File: tb/tb_control_seq.sv
// Directed self-checking bench for control_seq (registered and live flag variants).
module tb_control_seq;

  logic       clk;
  logic       reset_n;
  logic [7:0] ir;
  logic       mem_ready;
  logic [7:0] alu_result;
  logic       alu_carry;

  logic load_ir, pc_inc, load_pc, load_a, load_b, load_x, load_q, store_mem;
  logic [3:0] assert_bar;
  logic immediate, do_subtract, do_jump, halted, flag_z, flag_c;

  logic lvLoadIr, lvPcInc, lvLoadPc, lvLoadA, lvLoadB, lvLoadX, lvLoadQ, lvStoreMem;
  logic [3:0] lvAssertBar;
  logic lvImmediate, lvDoSubtract, lvDoJump, lvHalted, lvFlagZ, lvFlagC;

  logic [7:0] allStr;
  logic [5:0] strb;

  int checks = 0;
  int errors = 0;

  control_seq #(.DW(8), .FLAGS_LIVE(0)) dut (
    .clk(clk), .reset_n(reset_n), .ir(ir), .mem_ready(mem_ready),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .load_ir(load_ir), .pc_inc(pc_inc), .load_pc(load_pc), .load_a(load_a),
    .load_b(load_b), .load_x(load_x), .load_q(load_q), .store_mem(store_mem),
    .assert_bar(assert_bar), .immediate(immediate), .do_subtract(do_subtract),
    .do_jump(do_jump), .halted(halted), .flag_z(flag_z), .flag_c(flag_c)
  );

  control_seq #(.DW(8), .FLAGS_LIVE(1)) dutLive (
    .clk(clk), .reset_n(reset_n), .ir(ir), .mem_ready(mem_ready),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .load_ir(lvLoadIr), .pc_inc(lvPcInc), .load_pc(lvLoadPc), .load_a(lvLoadA),
    .load_b(lvLoadB), .load_x(lvLoadX), .load_q(lvLoadQ), .store_mem(lvStoreMem),
    .assert_bar(lvAssertBar), .immediate(lvImmediate), .do_subtract(lvDoSubtract),
    .do_jump(lvDoJump), .halted(lvHalted), .flag_z(lvFlagZ), .flag_c(lvFlagC)
  );

  assign allStr = {load_ir, pc_inc, load_pc, load_a, load_b, load_x, load_q, store_mem};
  assign strb   = allStr[5:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH, runs one instruction with memory ready, ends back in FETCH.
  task automatic runInstr(input logic [7:0] instr, input logic [5:0] expStr,
                          input logic [3:0] expBar, input string tag);
    ir        = instr;
    mem_ready = 1'b1;
    tick();
    chk({tag, "_strobes"}, {2'b00, strb}, {2'b00, expStr});
    chk({tag, "_bar"}, {4'h0, assert_bar}, {4'h0, expBar});
    tick();
    chk({tag, "_back_fetch"}, {7'd0, load_ir}, 8'd1);
  endtask

  initial begin
    reset_n    = 1'b0;
    ir         = 8'h00;
    mem_ready  = 1'b0;
    alu_result = 8'hFF;
    alu_carry  = 1'b0;
    #2;
    chk("rst_strobes", allStr, 8'h00);
    chk("rst_bar", {4'h0, assert_bar}, 8'h0F);
    chk("rst_flags", {6'd0, flag_z, flag_c}, 8'h00);
    chk("rst_halted", {7'd0, halted}, 8'h00);

    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    chk("post_rst_load_ir", {7'd0, load_ir}, 8'd1);
    chk("post_rst_bar", {4'h0, assert_bar}, 8'h0E);
    chk("post_rst_pc_inc", {7'd0, pc_inc}, 8'd0);
    tick();
    chk("fetch_wait_load_ir", {7'd0, load_ir}, 8'd1);

    // Load A from memory with a zero result and carry set.
    ir = 8'h02; mem_ready = 1'b1; alu_result = 8'h00; alu_carry = 1'b1;
    #1;
    chk("fetch_pc_inc", {7'd0, pc_inc}, 8'd1);
    tick();
    chk("lda_strobes", {2'b00, strb}, 8'b0001_0000);
    chk("lda_bar", {4'h0, assert_bar}, 8'h0E);
    chk("lda_immediate", {7'd0, immediate}, 8'd1);
    chk("lda_no_load_ir", {7'd0, load_ir}, 8'd0);
    tick();
    chk("lda_flags", {6'd0, flag_z, flag_c}, 8'b11);
    chk("lda_back_fetch", {7'd0, load_ir}, 8'd1);

    // Conditional jump on Z with registered Z=1; live variant sees a nonzero ALU.
    ir = 8'h51; alu_result = 8'h05; alu_carry = 1'b0;
    tick();
    chk("jz_taken_load_pc", {7'd0, load_pc}, 8'd1);
    chk("jz_taken_do_jump", {7'd0, do_jump}, 8'd1);
    chk("jz_bar", {4'h0, assert_bar}, 8'h0D);
    chk("live_jz_nonzero", {7'd0, lvLoadPc}, 8'd0);
    tick();

    // Clear both flags through a load A of a nonzero value.
    runInstr(8'h02, 6'b010000, 4'b1110, "lda_clr");
    chk("clr_flags", {6'd0, flag_z, flag_c}, 8'b00);

    // Not taken with registered Z=0; live variant sees a zero ALU and jumps.
    ir = 8'h51; alu_result = 8'h00;
    tick();
    chk("jz_not_taken", allStr, 8'h00);
    chk("live_flag_z", {7'd0, lvFlagZ}, 8'd0);
    chk("live_jz_taken", {7'd0, lvLoadPc}, 8'd1);
    tick();
    chk("not_taken_to_fetch", {7'd0, load_ir}, 8'd1);

    runInstr(8'hC1, 6'b100000, 4'b1110, "jmp_uncond");
    runInstr(8'h13, 6'b001000, 4'b1101, "ldb");
    runInstr(8'h3C, 6'b000100, 4'b0111, "ldx");
    runInstr(8'h46, 6'b000010, 4'b1110, "ldq");

    // Store to memory stalled for three cycles.
    ir = 8'h25; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("st_stall_store", {7'd0, store_mem}, 8'd0);
      chk("st_stall_bar", {4'h0, assert_bar}, 8'h0B);
      chk("st_stall_load_ir", {7'd0, load_ir}, 8'd0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("st_release", {7'd0, store_mem}, 8'd1);
    tick();
    chk("st_one_cycle", {7'd0, store_mem}, 8'd0);
    chk("st_back_fetch", {7'd0, load_ir}, 8'd1);

    // Set flags, then reset during a stalled load A.
    alu_carry = 1'b1;
    runInstr(8'h02, 6'b010000, 4'b1110, "lda_set");
    chk("set_flags", {6'd0, flag_z, flag_c}, 8'b11);
    ir = 8'h02; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("stall_lda", {7'd0, load_a}, 8'd0);
    mem_ready = 1'b1;
    #1;
    chk("stall_lda_ready", {7'd0, load_a}, 8'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_strobes", allStr, 8'h00);
    chk("mid_rst_bar", {4'h0, assert_bar}, 8'h0F);
    chk("mid_rst_flags", {6'd0, flag_z, flag_c}, 8'b00);
    chk("mid_rst_halted", {7'd0, halted}, 8'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    chk("rel_load_ir", {7'd0, load_ir}, 8'd1);
    chk("rel_no_load_a", {7'd0, load_a}, 8'd0);

    // Halt, then ignore memory activity until reset.
    ir = 8'h07; mem_ready = 1'b1;
    tick();
    chk("halt_exec_strobes", allStr, 8'h00);
    chk("halt_exec_halted", {7'd0, halted}, 8'd0);
    tick();
    chk("halt_halted", {7'd0, halted}, 8'd1);
    for (int i = 0; i < 12; i++) begin
      mem_ready = i[0];
      #1;
      chk("halt_strobes", allStr, 8'h00);
      chk("halt_bar", {4'h0, assert_bar}, 8'h0F);
      chk("halt_stay", {7'd0, halted}, 8'd1);
      tick();
    end
    reset_n = 1'b0;
    #2;
    chk("halt_rst_halted", {7'd0, halted}, 8'd0);
    reset_n = 1'b1;
    #1;
    chk("halt_rst_fetch", {7'd0, load_ir}, 8'd1);
    chk("halt_rst_halted_rel", {7'd0, halted}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
